adc0809_scan_arbiter: RTL and testbench

//  Shares one ADC0809 converter among N_REQ requesters (e.g. display path, fan control, logger).

---
 rtl/adc0809_scan_arbiter_pkg.sv | 29 ++
 rtl/adc0809_scan_arbiter_rr_arbiter.sv | 45 ++++
 rtl/adc0809_scan_arbiter.sv | 127 ++++++++++++
 tb/tb_adc0809_scan_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc0809_scan_arbiter_pkg.sv
// adc0809_scan_arbiter_pkg: FSM states, default timing parameters and ADC pin phases
package adc0809_scan_arbiter_pkg;

    localparam int DEF_CLK_DIV     = 100;
    localparam int DEF_EOC_TIMEOUT = 1024;
    localparam int DEF_EOC_LOW_MAX = 10;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_START, S_HOLD, S_WAIT_LOW, S_WAIT_HIGH, S_READ, S_LATCH
    } state_t;

    typedef struct packed {
        logic ale;
        logic st;
        logic oe;
    } pins_t;

    // ale/st/oe levels the ADC sees while the FSM sits in a given state
    function automatic pins_t phase(input state_t s);
        return '{ale: s == S_ADDR || s == S_START,
                 st:  s == S_START || s == S_HOLD,
                 oe:  s == S_READ || s == S_LATCH};
    endfunction

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1) % n;
    endfunction

endpackage

// File: rtl/adc0809_scan_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request at or after a registered pointer
//  clk, reset    : system clock, asynchronous active-low reset
//  req           : request vector
//  accept        : strobe, pointer moves past accept_idx
//  accept_idx    : index of the requester whose service just ended
//  pick, valid   : combinational winner and "some request present"
module rr_arbiter
    import adc0809_scan_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             accept,
    input  logic [IW-1:0]    accept_idx,
    output logic [IW-1:0]    pick,
    output logic             valid
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;

    // scanned from the farthest offset down so the nearest request wins
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (req[idx]) begin
                pick  = idx;
                valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            ptr <= '0;
        else if (accept)
            ptr <= IW'(wrap_inc(int'(accept_idx), N_REQ));

endmodule

// File: rtl/adc0809_scan_arbiter.sv
// adc0809_scan_arbiter: shares one ADC0809 among N_REQ requesters, round-robin
//  clk, reset        : system clock, asynchronous active-low reset
//  req, req_ch       : per-requester level request and 3-bit channel
//  eoc, dout         : ADC end-of-conversion (asynchronous) and data bus
//  clk_adc           : free-running conversion clock, CLK_DIV clk per half-period
//  addr/ale/st/oe    : ADC control pins
//  gnt, done         : one-hot grant and one-clk completion pulse
//  data_out          : last captured result
//  busy, timeout     : FSM not idle, one-clk abort pulse
module adc0809_scan_arbiter
    import adc0809_scan_arbiter_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int EOC_TIMEOUT = DEF_EOC_TIMEOUT,
    parameter int EOC_LOW_MAX = DEF_EOC_LOW_MAX
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [3*N_REQ-1:0] req_ch,
    input  logic               eoc,
    input  logic [7:0]         dout,
    output logic               clk_adc,
    output logic [2:0]         addr,
    output logic               ale,
    output logic               st,
    output logic               oe,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [7:0]         data_out,
    output logic               busy,
    output logic               timeout
);

    localparam int IW = $clog2(N_REQ);
    localparam int DW = $clog2(CLK_DIV);
    localparam int TW = $clog2((EOC_TIMEOUT > EOC_LOW_MAX ? EOC_TIMEOUT : EOC_LOW_MAX) + 1);

    logic [DW-1:0] cnt;
    logic [1:0]    eoc_q;
    logic [TW-1:0] tcnt;
    logic [IW-1:0] cur, pick;
    logic [2:0]    pick_ch;
    logic          tick, eoc_s, valid, abort, accept;
    state_t        state, nxt;

    // tick coincides with the clk edge on which clk_adc goes high
    assign tick   = cnt == DW'(CLK_DIV - 1) && !clk_adc;
    assign eoc_s  = eoc_q[1];
    assign accept = abort || state == S_LATCH;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .accept     (accept),
        .accept_idx (cur),
        .pick       (pick),
        .valid      (valid)
    );

    always_comb begin
        pick_ch = '0;
        for (int i = 0; i < N_REQ; i++)
            if (pick == IW'(i)) pick_ch = req_ch[3*i +: 3];
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt     <= '0;
            clk_adc <= 1'b0;
            eoc_q   <= '0;
        end else begin
            eoc_q   <= {eoc_q[0], eoc};
            cnt     <= cnt == DW'(CLK_DIV - 1) ? '0 : cnt + 1'b1;
            clk_adc <= cnt == DW'(CLK_DIV - 1) ? !clk_adc : clk_adc;
        end

    always_comb begin
        nxt   = state;
        abort = 1'b0;
        case (state)
            S_IDLE:      nxt = valid ? S_ADDR : S_IDLE;
            S_ADDR:      nxt = tick ? S_START : S_ADDR;
            S_START:     nxt = tick ? S_HOLD : S_START;
            S_HOLD:      nxt = tick ? S_WAIT_LOW : S_HOLD;
            S_WAIT_LOW:  nxt = tick && (!eoc_s || tcnt == TW'(EOC_LOW_MAX - 1)) ? S_WAIT_HIGH : S_WAIT_LOW;
            S_WAIT_HIGH: begin
                abort = tick && !eoc_s && tcnt == TW'(EOC_TIMEOUT - 1);
                nxt   = tick && eoc_s ? S_READ : abort ? S_IDLE : S_WAIT_HIGH;
            end
            S_READ:      nxt = tick ? S_LATCH : S_READ;
            default:     nxt = S_IDLE;
        endcase
    end

    // tcnt counts ticks spent in the current state and restarts on every move
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state        <= S_IDLE;
            {ale, st, oe} <= '0;
            tcnt         <= '0;
            cur          <= '0;
            addr         <= '0;
            gnt          <= '0;
            done         <= '0;
            data_out     <= '0;
            busy         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= nxt;
            {ale, st, oe} <= phase(nxt);
            busy         <= nxt != S_IDLE;
            timeout      <= abort;
            tcnt         <= nxt != state ? '0 : tcnt + TW'(tick);
            done         <= state == S_LATCH ? gnt : '0;
            if (state == S_IDLE && valid) begin
                cur  <= pick;
                addr <= pick_ch;
                gnt  <= N_REQ'(1) << pick;
            end
            if (accept) gnt <= '0;
            if (state == S_LATCH) data_out <= dout;
        end

endmodule

// File: tb/tb_adc0809_scan_arbiter.sv
// tb_adc0809_scan_arbiter: directed + randomized checks against a behavioural ADC and round-robin model
module tb_adc0809_scan_arbiter;

    localparam int N  = 4;
    localparam int CD = 2;
    localparam int ET = 16;
    localparam int EL = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [3*N-1:0] req_ch = '0;
    logic           eoc = 1'b1;
    logic [7:0]     dout = '0;
    logic           clk_adc, ale, st, oe, busy, timeout;
    logic [2:0]     addr;
    logic [N-1:0]   gnt, done;
    logic [7:0]     data_out;

    int vectors = 0, miscompares = 0;
    int ptr = 0, exp_dn = 0, dn_cnt = 0;
    logic [7:0] last_data = '0;

    adc0809_scan_arbiter #(.N_REQ(N), .CLK_DIV(CD), .EOC_TIMEOUT(ET), .EOC_LOW_MAX(EL)) dut (
        .clk(clk), .reset(reset), .req(req), .req_ch(req_ch), .eoc(eoc), .dout(dout),
        .clk_adc(clk_adc), .addr(addr), .ale(ale), .st(st), .oe(oe), .gnt(gnt), .done(done),
        .data_out(data_out), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ADC model: conversion starts on st falling, eoc low for a random span, then data on the bus
    bit         hang = 1'b0;
    int         fixed_val = -1;
    logic [2:0] conv_ch = '0;
    logic [7:0] conv_val = '0;
    int         conv_cnt = 0;
    logic       prev_st = 1'b0;

    always @(negedge clk) begin
        if (prev_st && !st) begin
            conv_ch  = addr;
            conv_val = fixed_val >= 0 ? 8'(fixed_val) : 8'($urandom_range(0, 255));
            conv_cnt = $urandom_range(12, 40);
        end else if (conv_cnt > 0)
            conv_cnt--;
        prev_st = st;
        eoc     = !hang && conv_cnt == 0;
        dout    = conv_val;
    end

    // protocol monitor: pin invariants, phase lengths, clk_adc duty, done pulse count
    logic [2:0] ppat = '0;
    int         prun = 0, crun = 0;
    bit         cval = 0;
    logic       pclk = 1'b0, pale = 1'b0;
    logic [2:0] paddr = '0;

    always @(negedge clk) begin
        if (!reset) begin
            ppat = '0; prun = 0; crun = 0; cval = 0; pclk = 1'b0; pale = 1'b0;
        end else begin
            if (st && oe) chk("st_with_oe", {st, oe}, 2'b00);
            if (!$onehot0(gnt)) chk("gnt_onehot0", gnt, 0);
            if (ale && pale && addr !== paddr) chk("addr_stable", addr, paddr);
            if (|done) dn_cnt++;
            if ({ale, st, oe} != ppat) begin
                if (ppat == 3'b100 && (prun < 1 || prun > 2 * CD)) chk("addr_phase", prun, 2 * CD);
                if (ppat == 3'b110 || ppat == 3'b010) chk("st_phase", prun, 2 * CD);
                if (ppat == 3'b001) chk("oe_phase", prun, 2 * CD + 1);
                ppat = {ale, st, oe};
                prun = 1;
            end else
                prun++;
            if (clk_adc != pclk) begin
                if (cval) chk("clk_adc_half", crun, CD);
                cval = 1;
                crun = 1;
                pclk = clk_adc;
            end else
                crun++;
            pale  = ale;
            paddr = addr;
        end
    end

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic wait_st(input logic lvl);
        bit got = 0;
        for (int n = 0; n < 2000 && !got; n++) begin
            @(negedge clk);
            got = st === lvl;
        end
        chk("st_wait", got, 1);
    endtask

    // waits for the completion of one conversion and checks it against the model
    task automatic serve(input int exp_idx, input logic [2:0] exp_ch);
        bit got = 0, gseen = 0;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk);
            if (busy && !gseen) begin
                chk("gnt", gnt, 1 << exp_idx);
                gseen = 1;
            end
            got = |done || timeout;
        end
        chk("serve_bound", got, 1);
        chk("done_idx", done, 1 << exp_idx);
        chk("no_timeout", timeout, 0);
        chk("data", data_out, conv_val);
        chk("channel", conv_ch, exp_ch);
        chk("gnt_clear", gnt, 0);
        chk("busy_clear", busy, 0);
        last_data = conv_val;
        exp_dn++;
        ptr = (exp_idx + 1) % N;
    endtask

    initial begin
        int w, n;
        bit got;
        repeat (3) @(negedge clk);
        chk("rst_pins", {clk_adc, ale, st, oe, busy, timeout}, 0);
        chk("rst_gnt_done", {gnt, done}, 0);
        chk("rst_data_addr", {data_out, addr}, 0);
        reset = 1'b1;

        // single requester, fixed result
        fixed_val = 8'hA5;
        req = 4'b0001;
        req_ch[2:0] = 3'd3;
        serve(0, 3'd3);
        chk("data_a5", data_out, 8'hA5);
        req = '0;
        fixed_val = -1;
        repeat (3) @(negedge clk);

        // all requesters held: strict rotation
        req = 4'b1111;
        req_ch = 12'($urandom);
        for (int i = 0; i < 5; i++) begin
            w = rr_pick(req, ptr);
            serve(w, req_ch[3*w +: 3]);
        end

        // random request subsets changed right after each completion
        for (int i = 0; i < 8; i++) begin
            req = 4'($urandom_range(1, 15));
            req_ch = 12'($urandom);
            w = rr_pick(req, ptr);
            serve(w, req_ch[3*w +: 3]);
        end
        req = '0;
        repeat (3) @(negedge clk);

        // eoc never returns: abort after ET ticks in WAIT_HIGH
        hang = 1'b1;
        req = 4'b1000;
        req_ch[11:9] = 3'd5;
        wait_st(1'b1);
        wait_st(1'b0);
        n = 0;
        got = 0;
        while (n < 3000 && !got) begin
            @(negedge clk);
            n++;
            got = timeout || |done;
        end
        chk("timeout_seen", timeout, 1);
        chk("timeout_latency", n, 2 * CD * (1 + ET));
        chk("timeout_no_done", done, 0);
        chk("timeout_data", data_out, last_data);
        chk("timeout_gnt", gnt, 0);
        ptr = (3 + 1) % N;
        req = '0;
        hang = 1'b0;
        @(negedge clk);
        chk("timeout_one_clk", timeout, 0);
        repeat (3) @(negedge clk);
        req = 4'b1001;
        req_ch = 12'($urandom);
        w = rr_pick(req, ptr);
        serve(w, req_ch[3*w +: 3]);
        req = '0;
        repeat (3) @(negedge clk);

        // reset while waiting for eoc
        hang = 1'b1;
        req = 4'b0001;
        wait_st(1'b1);
        wait_st(1'b0);
        repeat (20) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("mid_reset_pins", {ale, st, oe, busy, timeout}, 0);
        chk("mid_reset_gnt_done", {gnt, done}, 0);
        repeat (3) @(negedge clk);
        hang = 1'b0;
        req = 4'b0100;
        req_ch[8:6] = 3'd7;
        reset = 1'b1;
        ptr = 0;
        serve(2, 3'd7);
        req = '0;
        repeat (3) @(negedge clk);

        // request dropped and channel changed during HOLD
        req = 4'b0010;
        req_ch[5:3] = 3'd2;
        wait_st(1'b1);
        got = 0;
        for (int k = 0; k < 2000 && !got; k++) begin
            @(negedge clk);
            got = st && !ale;
        end
        chk("hold_seen", got, 1);
        req = '0;
        req_ch[5:3] = 3'd6;
        serve(1, 3'd2);

        repeat (5) @(negedge clk);
        chk("done_count", dn_cnt, exp_dn);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
